// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles every bus signal around the mem_bus arbiter. The requester ports are
// packed per requester: req_address[i*27 +: 27], req_wdata[i*16 +: 16] and
// req_wmask[i*2 +: 2] all belong to requester i.
//
// Signals
//   req_request/lock/write  per-requester request, burst lock, write flag
//   req_address/wdata/wmask per-requester payload
//   req_ack                 per-requester ack (only the owner ever sees one)
//   req_rdata               read data broadcast to all requesters
//   mem_request/write/...   single downstream bus towards the memory target
//   mem_ack/mem_rdata       downstream ack pulse and read data
//   grant_valid/grant_id    current bus owner
//
// Modports
//   slave  : the arbiter's view (it serves the requesters and the target)
//   master : the environment's view (requesters plus memory target)
//
// NUM_REQ must match the NUM_REQ of the connected arbiter.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_request;
    logic [NUM_REQ-1:0]    req_lock;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*27-1:0] req_address;
    logic [NUM_REQ*16-1:0] req_wdata;
    logic [NUM_REQ*2-1:0]  req_wmask;
    logic [NUM_REQ-1:0]    req_ack;
    logic [15:0]           req_rdata;

    logic                  mem_request;
    logic                  mem_ack;
    logic                  mem_write;
    logic [26:0]           mem_address;
    logic [15:0]           mem_wdata;
    logic [1:0]            mem_wmask;
    logic [15:0]           mem_rdata;

    logic                  grant_valid;
    logic [2:0]            grant_id;

    modport slave (
        input  req_request, req_lock, req_write, req_address, req_wdata, req_wmask,
        input  mem_ack, mem_rdata,
        output req_ack, req_rdata,
        output mem_request, mem_write, mem_address, mem_wdata, mem_wmask,
        output grant_valid, grant_id
    );

    modport master (
        output req_request, req_lock, req_write, req_address, req_wdata, req_wmask,
        output mem_ack, mem_rdata,
        input  req_ack, req_rdata,
        input  mem_request, mem_write, mem_address, mem_wdata, mem_wmask,
        input  grant_valid, grant_id
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SDRAM/flash mem_bus target between NUM_REQ controllers.
// Arbitration is round-robin per transaction; a requester holding req_lock on
// its ack keeps the bus for up to BURST_LIMIT back-to-back transfers. With
// PRIORITY_0=1 requester 0 always wins and the rest rotate among themselves.
//
// Ports
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      mem_bus_arbiter_if.slave (requester side, target side, grant)
//
// The downstream request/payload and the ack routing are combinational from
// the registered grant, so the only added latency is the one IDLE cycle spent
// on every fresh arbitration.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BURST_LIMIT = 16,
    parameter int PRIORITY_0  = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mem_bus_arbiter_if.slave       bus
);
    localparam int                IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0]    NUM_W         = (IDX_W+1)'(NUM_REQ);
    localparam logic [8:0]        BURST_LIMIT_W = 9'(BURST_LIMIT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   rr_pointer_q, rr_pointer_d;
    logic [7:0]         burst_count_q, burst_count_d;

    logic [NUM_REQ-1:0] onehot_s;
    logic               sel_request_s;
    logic               sel_lock_s;
    logic               sel_write_s;
    logic [26:0]        sel_address_s;
    logic [15:0]        sel_wdata_s;
    logic [1:0]         sel_wmask_s;
    logic [NUM_REQ-1:0] scan_req_s;
    logic [IDX_W-1:0]   winner_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [8:0]         burst_next_s;

    // Index addition modulo NUM_REQ (operands are always < NUM_REQ).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sum = (sum >= NUM_W) ? (sum - NUM_W) : sum;
        return sum[IDX_W-1:0];
    endfunction

    // First set bit at or above ptr, wrapping modulo NUM_REQ. The doubled
    // vector shifted right by ptr puts candidate ptr+k at bit k.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [2*NUM_REQ-1:0] rot;
        logic [IDX_W-1:0]     off;
        rot = {req, req} >> ptr;
        off = '0;
        // Scan downward so the lowest offset is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            off = rot[i] ? IDX_W'(i) : off;
        end
        return wrap_add(ptr, off);
    endfunction

    // Grant decode and request/payload mux for the current owner.
    always_comb begin
        onehot_s      = '0;
        sel_request_s = 1'b0;
        sel_lock_s    = 1'b0;
        sel_write_s   = 1'b0;
        sel_address_s = 27'd0;
        sel_wdata_s   = 16'd0;
        sel_wmask_s   = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            onehot_s[i]   = (grant_id_q == IDX_W'(i));
            sel_request_s = sel_request_s | (bus.req_request[i] & onehot_s[i]);
            sel_lock_s    = sel_lock_s    | (bus.req_lock[i]    & onehot_s[i]);
            sel_write_s   = sel_write_s   | (bus.req_write[i]   & onehot_s[i]);
            sel_address_s = sel_address_s | (bus.req_address[i*27 +: 27] & {27{onehot_s[i]}});
            sel_wdata_s   = sel_wdata_s   | (bus.req_wdata[i*16 +: 16]   & {16{onehot_s[i]}});
            sel_wmask_s   = sel_wmask_s   | (bus.req_wmask[i*2 +: 2]     & {2{onehot_s[i]}});
        end
    end

    // Arbitration winner and the pointer value used when the grant is released.
    always_comb begin
        scan_req_s = bus.req_request;
        if (PRIORITY_0 != 0) begin
            // Requester 0 is handled by fixed priority, keep it out of the rotation.
            scan_req_s[0] = 1'b0;
        end else begin
            scan_req_s[0] = bus.req_request[0];
        end

        if ((PRIORITY_0 != 0) && bus.req_request[0]) begin
            winner_s = '0;
        end else begin
            winner_s = rr_pick(scan_req_s, rr_pointer_q);
        end

        if ((PRIORITY_0 != 0) && (grant_id_q == '0)) begin
            // A fixed-priority win must not disturb the others' rotation.
            next_ptr_s = rr_pointer_q;
        end else begin
            next_ptr_s = wrap_add(grant_id_q, IDX_W'(1));
        end
    end

    // Next-state logic of the IDLE/GRANT controller.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        rr_pointer_d  = rr_pointer_q;
        burst_count_d = burst_count_q;
        burst_next_s  = {1'b0, burst_count_q} + 9'd1;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_request) begin
                    state_d       = ST_GRANT;
                    grant_id_d    = winner_s;
                    grant_valid_d = 1'b1;
                    burst_count_d = 8'd0;
                end else begin
                    state_d       = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // mem_ack is checked first so it wins over a same-cycle release.
                if (bus.mem_ack && sel_lock_s && (burst_next_s < BURST_LIMIT_W)) begin
                    burst_count_d = burst_next_s[7:0];
                end else if (bus.mem_ack || !sel_request_s) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    rr_pointer_d  = next_ptr_s;
                end else begin
                    state_d       = ST_GRANT;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            rr_pointer_q  <= '0;
            burst_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            rr_pointer_q  <= rr_pointer_d;
            burst_count_q <= burst_count_d;
        end
    end

    // Downstream bus: driven only while granted, payload follows the owner.
    assign bus.mem_request = (state_q == ST_GRANT) & sel_request_s;
    assign bus.mem_write   = sel_write_s;
    assign bus.mem_address = sel_address_s;
    assign bus.mem_wdata   = sel_wdata_s;
    assign bus.mem_wmask   = sel_wmask_s;

    // An ack outside GRANT (e.g. straight after reset) is dropped here.
    assign bus.req_ack     = onehot_s & {NUM_REQ{(state_q == ST_GRANT) & bus.mem_ack}};
    assign bus.req_rdata   = bus.mem_rdata;

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = 3'(grant_id_q);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Two arbiters share clock and reset:
//   dut_a : NUM_REQ=4, BURST_LIMIT=4,  PRIORITY_0=0 (bus ba)
//   dut_p : NUM_REQ=4, BURST_LIMIT=16, PRIORITY_0=1 (bus bp)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_REQ(4)) ba ();
    mem_bus_arbiter_if #(.NUM_REQ(4)) bp ();

    mem_bus_arbiter #(.NUM_REQ(4), .BURST_LIMIT(4), .PRIORITY_0(0)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ba)
    );

    mem_bus_arbiter #(.NUM_REQ(4), .BURST_LIMIT(16), .PRIORITY_0(1)) dut_p (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reset is sampled on the second edge; returns in an IDLE cycle.
    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        ba.req_request = 4'b0000; ba.req_lock = 4'b0000; ba.req_write = 4'b0000;
        ba.req_address = '0;      ba.req_wdata = '0;     ba.req_wmask = '0;
        ba.mem_ack     = 1'b0;    ba.mem_rdata = 16'hBEEF;
        bp.req_request = 4'b0000; bp.req_lock = 4'b0000; bp.req_write = 4'b0000;
        bp.req_address = '0;      bp.req_wdata = '0;     bp.req_wmask = '0;
        bp.mem_ack     = 1'b0;    bp.mem_rdata = 16'h0000;

        // ---- reset state ----
        tick();
        tick();
        at_neg();
        chk("rst_grant_valid", 32'(ba.grant_valid), 32'd0);
        chk("rst_grant_id",    32'(ba.grant_id),    32'd0);
        chk("rst_mem_request", 32'(ba.mem_request), 32'd0);
        chk("rst_req_ack",     32'(ba.req_ack),     32'd0);
        chk("rst_p_grant_valid", 32'(bp.grant_valid), 32'd0);
        chk("rdata_broadcast", 32'(ba.req_rdata),   32'hBEEF);

        // ---- 1: single write from requester 2 ----
        do_reset();
        ba.req_request            = 4'b0100;
        ba.req_write              = 4'b0100;
        ba.req_address[2*27 +: 27] = 27'h0000100;
        ba.req_wdata[2*16 +: 16]   = 16'hA55A;
        ba.req_wmask[2*2 +: 2]     = 2'b11;
        at_neg();
        chk("t1_bubble_mem_request", 32'(ba.mem_request), 32'd0);
        tick();
        at_neg();
        chk("t1_mem_request", 32'(ba.mem_request), 32'd1);
        chk("t1_mem_address", 32'(ba.mem_address), 32'h100);
        chk("t1_mem_wdata",   32'(ba.mem_wdata),   32'hA55A);
        chk("t1_mem_wmask",   32'(ba.mem_wmask),   32'd3);
        chk("t1_mem_write",   32'(ba.mem_write),   32'd1);
        chk("t1_grant_id",    32'(ba.grant_id),    32'd2);
        chk("t1_grant_valid", 32'(ba.grant_valid), 32'd1);
        chk("t1_no_early_ack", 32'(ba.req_ack),    32'd0);
        tick();
        tick();
        at_neg();
        chk("t1_mem_request_held", 32'(ba.mem_request), 32'd1);
        tick();
        ba.mem_ack = 1'b1;
        at_neg();
        chk("t1_req_ack", 32'(ba.req_ack), 32'b0100);
        tick();
        ba.mem_ack     = 1'b0;
        ba.req_request = 4'b0000;
        ba.req_write   = 4'b0000;
        at_neg();
        chk("t1_grant_valid_fall", 32'(ba.grant_valid), 32'd0);
        chk("t1_mem_request_fall", 32'(ba.mem_request), 32'd0);

        // ---- 2: four requesters, unlocked round robin ----
        do_reset();
        ba.req_address = {27'h0003000, 27'h0002000, 27'h0001000, 27'h0000000};
        ba.req_request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            at_neg();
            chk($sformatf("t2_grant_id_%0d", k),   32'(ba.grant_id),    32'(k % 4));
            chk($sformatf("t2_mem_request_%0d", k), 32'(ba.mem_request), 32'd1);
            chk($sformatf("t2_mem_address_%0d", k), 32'(ba.mem_address), 32'((k % 4) * 32'h1000));
            chk($sformatf("t2_no_ack_%0d", k),      32'(ba.req_ack),     32'd0);
            tick();
            ba.mem_ack = 1'b1;
            at_neg();
            chk($sformatf("t2_req_ack_%0d", k),     32'(ba.req_ack),     32'd1 << (k % 4));
            tick();
            ba.mem_ack = 1'b0;
            at_neg();
            chk($sformatf("t2_idle_valid_%0d", k),  32'(ba.grant_valid), 32'd0);
            chk($sformatf("t2_idle_mem_req_%0d", k), 32'(ba.mem_request), 32'd0);
        end
        ba.req_request = 4'b0000;

        // ---- 3: locked burst of requester 1, BURST_LIMIT=4 ----
        do_reset();
        ba.req_request = 4'b1010;
        ba.req_lock    = 4'b0010;
        tick();
        ba.mem_ack = 1'b1;
        at_neg();
        chk("t3_grant_id_b0",  32'(ba.grant_id), 32'd1);
        chk("t3_req_ack_b0",   32'(ba.req_ack),  32'b0010);
        for (int b = 1; b < 4; b++) begin
            tick();
            at_neg();
            chk($sformatf("t3_grant_id_b%0d", b),    32'(ba.grant_id),    32'd1);
            chk($sformatf("t3_mem_request_b%0d", b), 32'(ba.mem_request), 32'd1);
            chk($sformatf("t3_req_ack_b%0d", b),     32'(ba.req_ack),     32'b0010);
        end
        tick();
        ba.mem_ack = 1'b0;
        at_neg();
        chk("t3_burst_end_valid", 32'(ba.grant_valid), 32'd0);
        tick();
        at_neg();
        chk("t3_next_grant_id",    32'(ba.grant_id),    32'd3);
        chk("t3_next_grant_valid", 32'(ba.grant_valid), 32'd1);
        tick();
        ba.mem_ack = 1'b1;
        at_neg();
        chk("t3_req_ack_3", 32'(ba.req_ack), 32'b1000);
        tick();
        ba.mem_ack     = 1'b0;
        ba.req_request = 4'b0000;
        ba.req_lock    = 4'b0000;
        at_neg();
        chk("t3_final_idle", 32'(ba.grant_valid), 32'd0);

        // ---- 4: fixed priority of requester 0 ----
        do_reset();
        bp.req_request = 4'b0101;
        for (int r = 0; r < 3; r++) begin
            tick();
            at_neg();
            chk($sformatf("t4_grant_id_%0d", r),    32'(bp.grant_id),    32'd0);
            chk($sformatf("t4_grant_valid_%0d", r), 32'(bp.grant_valid), 32'd1);
            tick();
            bp.mem_ack = 1'b1;
            at_neg();
            chk($sformatf("t4_req_ack_%0d", r), 32'(bp.req_ack), 32'b0001);
            tick();
            bp.mem_ack = 1'b0;
            if (r == 2) bp.req_request = 4'b0100;
            at_neg();
            chk($sformatf("t4_idle_%0d", r), 32'(bp.grant_valid), 32'd0);
        end
        tick();
        at_neg();
        chk("t4_grant_id_2",    32'(bp.grant_id),    32'd2);
        chk("t4_grant_valid_2", 32'(bp.grant_valid), 32'd1);
        tick();
        bp.mem_ack = 1'b1;
        at_neg();
        chk("t4_req_ack_2", 32'(bp.req_ack), 32'b0100);
        tick();
        bp.mem_ack     = 1'b0;
        bp.req_request = 4'b0000;

        // ---- 5: release without ack ----
        do_reset();
        ba.req_request = 4'b0110;
        tick();
        at_neg();
        chk("t5_grant_id_1", 32'(ba.grant_id), 32'd1);
        tick();
        ba.req_request = 4'b0100;
        at_neg();
        chk("t5_release_mem_req", 32'(ba.mem_request), 32'd0);
        tick();
        at_neg();
        chk("t5_release_idle", 32'(ba.grant_valid), 32'd0);
        tick();
        at_neg();
        chk("t5_grant_id_2",    32'(ba.grant_id),    32'd2);
        chk("t5_grant_valid_2", 32'(ba.grant_valid), 32'd1);
        chk("t5_mem_request_2", 32'(ba.mem_request), 32'd1);
        tick();
        ba.mem_ack = 1'b1;
        at_neg();
        chk("t5_req_ack_2", 32'(ba.req_ack), 32'b0100);
        tick();
        ba.mem_ack     = 1'b0;
        ba.req_request = 4'b0000;

        // ---- 6: reset mid-transfer, late ack dropped ----
        // Pointer is 3 here, so requester 0 only wins afterwards if reset cleared it.
        ba.req_request = 4'b0001;
        tick();
        at_neg();
        chk("t6_grant_id_0",    32'(ba.grant_id),    32'd0);
        chk("t6_mem_request_0", 32'(ba.mem_request), 32'd1);
        tick();
        reset_n        = 1'b0;
        ba.req_request = 4'b1001;
        tick();
        reset_n    = 1'b1;
        ba.mem_ack = 1'b1;
        at_neg();
        chk("t6_ack_dropped",   32'(ba.req_ack),     32'd0);
        chk("t6_grant_valid",   32'(ba.grant_valid), 32'd0);
        chk("t6_grant_id_rst",  32'(ba.grant_id),    32'd0);
        chk("t6_mem_request",   32'(ba.mem_request), 32'd0);
        tick();
        ba.mem_ack = 1'b0;
        at_neg();
        chk("t6_rearb_grant_id",    32'(ba.grant_id),    32'd0);
        chk("t6_rearb_grant_valid", 32'(ba.grant_valid), 32'd1);
        tick();
        ba.req_request = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
